vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 33 +++
 rtl/sync_delay.sv | 33 +++
 rtl/vga_timing.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: 720x400@70 defaults, counter widths and sync helper.
// Imported by the timing generator and by text-driver users of the same mode.
package vga_pkg;

    localparam int X_W     = 12;
    localparam int Y_W     = 11;
    localparam int FRAME_W = 16;

    localparam int H_ACTIVE_720 = 720;
    localparam int H_FP_720     = 18;
    localparam int H_SYNC_720   = 108;
    localparam int H_BP_720     = 54;

    localparam int V_ACTIVE_400 = 400;
    localparam int V_FP_400     = 12;
    localparam int V_SYNC_400   = 2;
    localparam int V_BP_400     = 35;

    localparam logic HSYNC_POL_720 = 1'b0;
    localparam logic VSYNC_POL_400 = 1'b1;

    localparam int H_TOTAL_720 = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;
    localparam int V_TOTAL_400 = V_ACTIVE_400 + V_FP_400 + V_SYNC_400 + V_BP_400;

    // Minimum counter widths for the default mode; the ports use the wider X_W/Y_W.
    localparam int H_TOTAL_W = $clog2(H_TOTAL_720);
    localparam int V_TOTAL_W = $clog2(V_TOTAL_400);

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Parameterised shift register that delays a bundle of sync signals by DEPTH clocks.
// DEPTH = 0 is a plain wire-through; every stage resets to RST_VAL.
module sync_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        // NOTE: these stages are real pipeline state feeding outputs, so each one gets
        // a reset value; a RAM-style array with no reset would leave glitches on sync.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: x/y counters, active/eol/eos flags, delayed syncs
// and a completed-frame counter; all outputs registered and aligned with x/y.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_720,
    parameter int   H_FP       = H_FP_720,
    parameter int   H_SYNC     = H_SYNC_720,
    parameter int   H_BP       = H_BP_720,
    parameter int   V_ACTIVE   = V_ACTIVE_400,
    parameter int   V_FP       = V_FP_400,
    parameter int   V_SYNC     = V_SYNC_400,
    parameter int   V_BP       = V_BP_400,
    parameter logic HSYNC_POL  = HSYNC_POL_720,
    parameter logic VSYNC_POL  = VSYNC_POL_400,
    parameter int   SYNC_DELAY = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en,
    output logic               h_active,
    output logic               v_active,
    output logic               eol,
    output logic               eos,
    output logic               hsync,
    output logic               vsync,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [FRAME_W-1:0] frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACTIVE = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_ACTIVE = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [FRAME_W-1:0] frame_q;
    logic [X_W-1:0]     x_nxt;
    logic [Y_W-1:0]     y_nxt;
    logic               frame_wrap;
    logic               started;
    logic               hs_raw;
    logic               vs_raw;
    logic [1:0]         sync_q;

    // The first enabled clock after reset presents position 0,0 rather than advancing.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        x_nxt      = x;
        y_nxt      = y;
        frame_wrap = 1'b0;
        if (started) begin
            if (x == X_LAST) begin
                x_nxt = '0;
                if (y == Y_LAST) begin
                    y_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nxt = y + 1'b1;
                end
            end else begin
                x_nxt = x + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and the block order cannot create races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            started  <= 1'b0;
            x        <= '0;
            y        <= '0;
            frame_q  <= '0;
            h_active <= 1'b0;
            v_active <= 1'b0;
            eol      <= 1'b0;
            eos      <= 1'b0;
            hs_raw   <= ~HSYNC_POL;
            vs_raw   <= ~VSYNC_POL;
        end else if (en) begin
            started  <= 1'b1;
            x        <= x_nxt;
            y        <= y_nxt;
            h_active <= (x_nxt < X_ACTIVE);
            v_active <= (y_nxt < Y_ACTIVE);
            eol      <= (x_nxt == X_ACTIVE);
            eos      <= (x_nxt == X_ACTIVE) && (y_nxt == Y_LAST);
            hs_raw   <= sync_level((x_nxt >= HS_START) && (x_nxt < HS_END), HSYNC_POL);
            vs_raw   <= sync_level((y_nxt >= VS_START) && (y_nxt < VS_END), VSYNC_POL);
            if (frame_wrap) frame_q <= frame_q + 1'b1;
        end else begin
            // Paused: position and frame hold, flags drop, syncs go idle.
            h_active <= 1'b0;
            v_active <= 1'b0;
            eol      <= 1'b0;
            eos      <= 1'b0;
            hs_raw   <= ~HSYNC_POL;
            vs_raw   <= ~VSYNC_POL;
        end
    end

    sync_delay #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (2),
        .RST_VAL ({~VSYNC_POL, ~HSYNC_POL})
    ) u_sync_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     ({vs_raw, hs_raw}),
        .q     (sync_q)
    );

    assign {vsync, hsync} = sync_q;
    assign frame          = frame_q;

endmodule
